// File: rtl/boot_memory_unit.sv
// Unified program/data memory with a boot loader front end: zero-fill, load an
// image over a valid/ready port while holding the CPU in reset, then serve the CPU bus.
module boot_memory_unit #(
  parameter int WIDTH         = 8,
  parameter int DEPTH         = 256,
  parameter bit CLEAR_ON_BOOT = 1'b1
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] address,
  input  logic [1:0]       rw_flag,
  input  logic [WIDTH-1:0] write_memory_value,
  output logic [WIDTH-1:0] read_memory_value,
  input  logic             LOAD_VALID,
  input  logic [WIDTH-1:0] LOAD_DATA,
  input  logic             LOAD_LAST,
  output logic             LOAD_READY,
  output logic             CPU_RESET,
  output logic             BOOT_DONE
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);
  localparam logic [WIDTH:0] DEPTH_LIM = (WIDTH + 1)'(DEPTH);
  // MEMORY_FLAG_TYPE: 2'b00 MEMORY_STAY, 2'b01 MEMORY_READ, 2'b10 MEMORY_WRITE
  localparam logic [1:0] MEMORY_WRITE = 2'b10;

  typedef enum logic [1:0] {
    S_CLEAR,
    S_LOAD,
    S_RELEASE,
    S_RUN
  } state_t;

  localparam state_t BOOT_STATE = CLEAR_ON_BOOT ? S_CLEAR : S_LOAD;

  state_t           state, next_state;
  logic [AW-1:0]    ptr, next_ptr;
  logic [WIDTH-1:0] mem [DEPTH];

  logic             load_fire;
  logic             addr_ok;
  logic [AW-1:0]    addr_idx;
  logic             mem_we;
  logic [AW-1:0]    mem_waddr;
  logic [WIDTH-1:0] mem_wdata;

  assign load_fire = (state == S_LOAD) && LOAD_READY && LOAD_VALID;
  assign addr_ok   = ({1'b0, address} < DEPTH_LIM);
  assign addr_idx  = address[AW-1:0];

  always_comb begin
    next_state = state;
    next_ptr   = ptr;
    case (state)
      S_CLEAR: begin
        if (ptr == LAST_PTR) begin
          next_ptr   = '0;
          next_state = S_LOAD;
        end else begin
          next_ptr = ptr + 1'b1;
        end
      end
      S_LOAD: begin
        if (load_fire) begin
          // Hold ptr on the final slot so an overflowing image never wraps.
          if (ptr != LAST_PTR) next_ptr = ptr + 1'b1;
          if (LOAD_LAST || ptr == LAST_PTR) next_state = S_RELEASE;
        end
      end
      S_RELEASE: next_state = S_RUN;
      S_RUN:     next_state = S_RUN;
      default:   next_state = BOOT_STATE;
    endcase
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state      <= BOOT_STATE;
      ptr        <= '0;
      LOAD_READY <= 1'b0;
      CPU_RESET  <= 1'b1;
      BOOT_DONE  <= 1'b0;
    end else begin
      state      <= next_state;
      ptr        <= next_ptr;
      LOAD_READY <= (next_state == S_LOAD);
      CPU_RESET  <= (next_state != S_RUN);
      BOOT_DONE  <= (next_state == S_RUN);
    end
  end

  // Single write port shared by the clear sweep, the loader and the CPU.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = ptr;
    mem_wdata = '0;
    case (state)
      S_CLEAR: mem_we = 1'b1;
      S_LOAD: begin
        if (load_fire) begin
          mem_we    = 1'b1;
          mem_wdata = LOAD_DATA;
        end
      end
      S_RUN: begin
        if (rw_flag == MEMORY_WRITE && addr_ok) begin
          mem_we    = 1'b1;
          mem_waddr = addr_idx;
          mem_wdata = write_memory_value;
        end
      end
      default: mem_we = 1'b0;
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      read_memory_value <= '0;
    end else if (state == S_RUN && addr_ok) begin
      read_memory_value <= mem[addr_idx];
    end else begin
      read_memory_value <= '0;
    end
  end

endmodule

// File: tb/tb_boot_memory_unit.sv
// Self-checking bench for boot_memory_unit: a 256-word and a 16-word instance
// compared each cycle against a phase/counter model, plus directed literal checks.
module tb_boot_memory_unit;

  localparam logic [1:0] STAY = 2'b00;
  localparam logic [1:0] RD   = 2'b01;
  localparam logic [1:0] WR   = 2'b10;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst    [2];
  logic [7:0] addr   [2];
  logic [1:0] rw     [2];
  logic [7:0] wdata  [2];
  logic [7:0] rdata  [2];
  logic       lvalid [2];
  logic [7:0] ldata  [2];
  logic       llast  [2];
  logic       lready [2];
  logic       cpurst [2];
  logic       done   [2];

  int total = 0;
  int bad   = 0;
  bit chk   = 1'b0;

  boot_memory_unit #(.WIDTH(8), .DEPTH(256), .CLEAR_ON_BOOT(1'b1)) dut (
    .CLOCK(clk), .RESET(rst[0]), .address(addr[0]), .rw_flag(rw[0]),
    .write_memory_value(wdata[0]), .read_memory_value(rdata[0]),
    .LOAD_VALID(lvalid[0]), .LOAD_DATA(ldata[0]), .LOAD_LAST(llast[0]),
    .LOAD_READY(lready[0]), .CPU_RESET(cpurst[0]), .BOOT_DONE(done[0])
  );

  boot_memory_unit #(.WIDTH(8), .DEPTH(16), .CLEAR_ON_BOOT(1'b1)) dut16 (
    .CLOCK(clk), .RESET(rst[1]), .address(addr[1]), .rw_flag(rw[1]),
    .write_memory_value(wdata[1]), .read_memory_value(rdata[1]),
    .LOAD_VALID(lvalid[1]), .LOAD_DATA(ldata[1]), .LOAD_LAST(llast[1]),
    .LOAD_READY(lready[1]), .CPU_RESET(cpurst[1]), .BOOT_DONE(done[1])
  );

  function automatic int dpt(input int k);
    return (k == 0) ? 256 : 16;
  endfunction

  task automatic check(input string nm, input int got, input int want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, got, want);
    end
  endtask

  // Model: phase 0 zero-fill (counts DEPTH cycles), 1 loading, 2 release, 3 run.
  int         m_ph  [2];
  int         m_cnt [2];
  int         m_ptr [2];
  logic [7:0] m_rd  [2];
  logic [7:0] m_mem [2][256];

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst[k]) begin
        m_ph[k]  <= 0;
        m_cnt[k] <= 0;
        m_ptr[k] <= 0;
        m_rd[k]  <= '0;
      end else begin
        m_rd[k] <= '0;
        case (m_ph[k])
          0: begin
            m_cnt[k] <= m_cnt[k] + 1;
            if (m_cnt[k] + 1 == dpt(k)) begin
              for (int i = 0; i < 256; i++) m_mem[k][i] <= '0;
              m_ptr[k] <= 0;
              m_ph[k]  <= 1;
            end
          end
          1: begin
            if (lvalid[k]) begin
              m_mem[k][m_ptr[k]] <= ldata[k];
              m_ptr[k] <= m_ptr[k] + 1;
              if (llast[k] || m_ptr[k] + 1 == dpt(k)) m_ph[k] <= 2;
            end
          end
          2: m_ph[k] <= 3;
          default: begin
            if (int'(addr[k]) < dpt(k)) begin
              m_rd[k] <= m_mem[k][addr[k]];
              if (rw[k] == WR) m_mem[k][addr[k]] <= wdata[k];
            end
          end
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (chk) begin
      for (int k = 0; k < 2; k++) begin
        check($sformatf("u%0d.read_memory_value", k), int'(rdata[k]), int'(m_rd[k]));
        check($sformatf("u%0d.LOAD_READY", k), int'(lready[k]), int'(m_ph[k] == 1));
        check($sformatf("u%0d.CPU_RESET", k), int'(cpurst[k]), int'(m_ph[k] != 3));
        check($sformatf("u%0d.BOOT_DONE", k), int'(done[k]), int'(m_ph[k] == 3));
      end
    end
  end

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic send(input int k, input logic [7:0] d, input logic last, output bit took);
    lvalid[k] = 1'b1;
    ldata[k]  = d;
    llast[k]  = last;
    took      = lready[k];
    cyc();
    lvalid[k] = 1'b0;
    llast[k]  = 1'b0;
  endtask

  task automatic rd(input int k, input logic [7:0] a, output logic [7:0] v);
    addr[k] = a;
    rw[k]   = RD;
    cyc();
    v = rdata[k];
  endtask

  task automatic wait_ready(input int k, input int want);
    int n = 0;
    while (lready[k] !== 1'b1 && n < 1000) begin
      cyc();
      n++;
    end
    check($sformatf("u%0d.clear_cycles", k), n, want);
  endtask

  task automatic rst_pulse(input int k);
    rst[k] = 1'b1;
    #1;
    check($sformatf("u%0d.async_cpu_reset", k), int'(cpurst[k]), 1);
    check($sformatf("u%0d.async_ready", k), int'(lready[k]), 0);
    check($sformatf("u%0d.async_done", k), int'(done[k]), 0);
    cyc();
    rst[k] = 1'b0;
  endtask

  initial begin
    bit         t;
    int         acc;
    int         nz;
    logic [7:0] v;
    logic [7:0] img [4];
    img[0] = 8'h03; img[1] = 8'h05; img[2] = 8'h1B; img[3] = 8'hF0;
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b1; addr[k] = '0; rw[k] = STAY; wdata[k] = '0;
      lvalid[k] = 1'b0; ldata[k] = '0; llast[k] = 1'b0;
    end
    cyc();
    cyc();
    chk = 1'b1;

    // zero-fill timing
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    wait_ready(0, 256);

    // load a 4-word image
    acc = 0;
    for (int i = 0; i < 4; i++) begin
      send(0, img[i], (i == 3), t);
      acc += int'(t);
    end
    check("u0.accepted", acc, 4);
    check("u0.release_cpu_reset", int'(cpurst[0]), 1);
    check("u0.release_done", int'(done[0]), 0);
    cyc();
    check("u0.run_cpu_reset", int'(cpurst[0]), 0);
    check("u0.run_done", int'(done[0]), 1);

    // full sweep: image then zeros
    nz = 0;
    for (int a = 0; a < 256; a++) begin
      rd(0, 8'(a), v);
      if (a < 4) check($sformatf("u0.img[%0d]", a), int'(v), int'(img[a]));
      else if (v != 8'h00) nz++;
    end
    check("u0.zero_fill", nz, 0);
    rd(0, 8'h02, v);
    check("u0.read_02", int'(v), 8'h1B);

    // read-before-write, then STAY does not write
    addr[0] = 8'h80; rw[0] = WR; wdata[0] = 8'h2A;
    cyc();
    check("u0.rbw_old", int'(rdata[0]), 8'h00);
    rd(0, 8'h80, v);
    check("u0.rbw_new", int'(v), 8'h2A);
    addr[0] = 8'h81; rw[0] = STAY; wdata[0] = 8'h55;
    cyc();
    rd(0, 8'h81, v);
    check("u0.stay_nowrite", int'(v), 8'h00);

    // reset mid-load wipes the partial image and the earlier run write
    rst_pulse(0);
    wait_ready(0, 256);
    send(0, 8'h11, 1'b0, t);
    send(0, 8'h22, 1'b0, t);
    rst_pulse(0);
    wait_ready(0, 256);
    send(0, 8'hAA, 1'b0, t);
    send(0, 8'hBB, 1'b1, t);
    cyc();
    rd(0, 8'h00, v); check("u0.reload0", int'(v), 8'hAA);
    rd(0, 8'h01, v); check("u0.reload1", int'(v), 8'hBB);
    rd(0, 8'h02, v); check("u0.reload2", int'(v), 8'h00);
    rd(0, 8'h03, v); check("u0.reload3", int'(v), 8'h00);
    rd(0, 8'h80, v); check("u0.rewiped80", int'(v), 8'h00);

    // 16-word instance: overflowing image, out-of-range port access
    acc = 0;
    for (int i = 0; i < 20; i++) begin
      send(1, 8'(8'h31 + i), 1'b0, t);
      acc += int'(t);
    end
    check("u1.accepted", acc, 16);
    check("u1.ready_after", int'(lready[1]), 0);
    rd(1, 8'h0F, v); check("u1.last_word", int'(v), 8'h40);
    rd(1, 8'h10, v); check("u1.oob_read", int'(v), 8'h00);
    addr[1] = 8'h10; rw[1] = WR; wdata[1] = 8'h77;
    cyc();
    rd(1, 8'h10, v); check("u1.oob_write", int'(v), 8'h00);
    rd(1, 8'h00, v); check("u1.no_alias", int'(v), 8'h31);

    // toggled LOAD_VALID
    rst_pulse(1);
    wait_ready(1, 16);
    acc = 0;
    for (int i = 0; i < 5; i++) begin
      send(1, 8'(8'h60 + i), (i == 4), t);
      acc += int'(t);
      if (i < 4) cyc();
    end
    check("u1.toggle_accepted", acc, 5);
    cyc();
    for (int a = 0; a < 6; a++) begin
      rd(1, 8'(a), v);
      check($sformatf("u1.toggle[%0d]", a), int'(v), (a < 5) ? 8'h60 + a : 0);
    end
    send(1, 8'hEE, 1'b1, t);
    check("u1.run_load_ignored", int'(t), 0);
    rd(1, 8'h05, v); check("u1.run_load_nowrite", int'(v), 8'h00);

    cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
